// File: rtl/flog_pkg.sv
// Shared types, bfloat16 constants and the special-operand classifier for the flog arbiter.
package flog_pkg;

    localparam int unsigned FLOG_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } flog_state_e;

    localparam logic [FLOG_W-1:0] QNAN    = 16'h7FC0;
    localparam logic [FLOG_W-1:0] POS_INF = 16'h7F80;
    localparam logic [FLOG_W-1:0] NEG_INF = 16'hFF80;
    localparam logic [FLOG_W-1:0] ONE     = 16'h3F80;
    localparam logic [FLOG_W-1:0] ZERO    = 16'h0000;

    typedef struct packed {
        logic              bypass;
        logic [FLOG_W-1:0] value;
    } flog_cls_t;

    // Resolve operands whose log2 is known without iterating; first match wins.
    function automatic flog_cls_t flog_classify(input logic [FLOG_W-1:0] op);
        flog_cls_t c;
        c.bypass = 1'b1;
        c.value  = ZERO;
        if (op[14:7] == 8'h00) begin
            c.value = NEG_INF;
        end else if (op[15]) begin
            c.value = QNAN;
        end else if (op[14:7] == 8'hFF) begin
            c.value = (op[6:0] == 7'd0) ? POS_INF : QNAN;
        end else if (op == ONE) begin
            c.value = ZERO;
        end else begin
            c.bypass = 1'b0;
        end
        return c;
    endfunction

endpackage

// File: rtl/flog_rr_picker.sv
// Rotating-priority picker: first set request at or above ptr_i, wrapping to 0.
module flog_rr_picker #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [ID_W-1:0]  id_o,
    output logic             any_o
);

    always_comb begin
        int idx;
        grant_o = '0;
        id_o    = '0;
        any_o   = 1'b0;
        idx     = 0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            idx = (int'(ptr_i) + i) % int'(N_REQ);
            if (!any_o && req_i[ID_W'(idx)]) begin
                any_o               = 1'b1;
                grant_o[ID_W'(idx)] = 1'b1;
                id_o                = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/flog_arbiter.sv
// Round-robin arbiter/sequencer sharing one iterative bfloat16 log2 core among N_REQ clients.
// Optional core watchdog enabled by defining FLOG_ARB_TIMEOUT_EN.
module flog_arbiter
    import flog_pkg::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned W              = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [N_REQ*W-1:0] req_data_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic               core_start_o,
    output logic [W-1:0]       core_operand_o,
    input  logic [W-1:0]       core_result_i,
    input  logic               core_done_i,
    output logic [N_REQ-1:0]   res_valid_o,
    output logic [W-1:0]       res_data_o,
    output logic               res_err_o,
    output logic               busy_o
);

    localparam int unsigned ID_W = $clog2(N_REQ);

    flog_state_e      r_state;
    flog_state_e      w_state_nxt;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  w_ptr_nxt;
    logic [ID_W-1:0]  r_gid;
    logic [ID_W-1:0]  w_gid_nxt;
    logic [ID_W-1:0]  w_pick_id;
    logic [N_REQ-1:0] w_pick_oh;
    logic             w_pick_any;
    logic [N_REQ-1:0] w_ready;
    logic [N_REQ-1:0] r_res_valid;
    logic [W-1:0]     r_operand;
    logic [W-1:0]     w_operand_nxt;
    logic [W-1:0]     r_result;
    logic [W-1:0]     w_result_nxt;
    logic [W-1:0]     w_req_op;
    logic             r_core_start;
    logic             r_busy;
    logic             w_tmo;
    flog_cls_t        w_cls;

    flog_rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .req_i   (req_valid_i),
        .ptr_i   (r_ptr),
        .grant_o (w_pick_oh),
        .id_o    (w_pick_id),
        .any_o   (w_pick_any)
    );

    assign w_req_op = req_data_i[int'(w_pick_id) * int'(W) +: W];
    assign w_cls    = flog_classify(FLOG_W'(w_req_op));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the operand/result/grant bookkeeping that rides on each transition.
    always_comb begin
        w_state_nxt   = r_state;
        w_ready       = '0;
        w_ptr_nxt     = r_ptr;
        w_gid_nxt     = r_gid;
        w_operand_nxt = r_operand;
        w_result_nxt  = r_result;
        unique case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_ready       = w_pick_oh;
                    w_gid_nxt     = w_pick_id;
                    w_operand_nxt = w_req_op;
                    w_ptr_nxt     = (w_pick_id == ID_W'(N_REQ - 1)) ? '0 : w_pick_id + ID_W'(1);
                    if (w_cls.bypass) begin
                        w_result_nxt = W'(w_cls.value);
                        w_state_nxt  = RESP;
                    end else begin
                        w_state_nxt  = BUSY;
                    end
                end
            end
            BUSY: begin
                if (core_done_i) begin
                    w_result_nxt = core_result_i;
                    w_state_nxt  = RESP;
                end else if (w_tmo) begin
                    w_result_nxt = W'(QNAN);
                    w_state_nxt  = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs are derived from the state being entered so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= '0;
            r_gid        <= '0;
            r_operand    <= '0;
            r_result     <= '0;
            r_core_start <= 1'b0;
            r_busy       <= 1'b0;
            r_res_valid  <= '0;
        end else begin
            r_ptr        <= w_ptr_nxt;
            r_gid        <= w_gid_nxt;
            r_operand    <= w_operand_nxt;
            r_result     <= w_result_nxt;
            r_core_start <= (w_state_nxt == BUSY);
            r_busy       <= (w_state_nxt != IDLE);
            r_res_valid  <= (w_state_nxt == RESP) ? (N_REQ'(1) << w_gid_nxt) : '0;
        end
    end

`ifdef FLOG_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_err;

    // Counts BUSY cycles; held at zero outside BUSY so every entry starts fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state != BUSY) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    assign w_tmo = (r_state == BUSY) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Error flag follows the result it qualifies; a same-cycle done beats the watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_state_nxt == RESP) begin
            r_err <= (r_state == BUSY) && !core_done_i && w_tmo;
        end
    end

    assign res_err_o = r_err;
`else
    assign w_tmo     = 1'b0;
    assign res_err_o = 1'b0;
`endif

    assign req_ready_o    = w_ready;
    assign core_start_o   = r_core_start;
    assign core_operand_o = r_operand;
    assign res_valid_o    = r_res_valid;
    assign res_data_o     = r_result;
    assign busy_o         = r_busy;

endmodule
